// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and state encoding for the mux scan controller
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: lowest enabled channel above cur, or lowest enabled overall when from_none
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              from_none,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && (from_none || i > int'(cur))) begin
        nxt = SEL_W'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select over enabled channels, settles, and captures one bit per channel
module mux_scan_ctrl #(
  parameter int SETTLE_W = 4,
  parameter int NUM_CH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_CH-1:0]              mask,
  input  logic [SETTLE_W-1:0]            settle,
  input  logic                           y_in,
  output logic [mux_scan_pkg::SEL_W-1:0] s,
  output logic [NUM_CH-1:0]              result,
  output logic                           busy,
  output logic                           done
);
  import mux_scan_pkg::*;
  logic [1:0] state;
  logic [NUM_CH-1:0] mask_q;
  logic [SETTLE_W-1:0] settle_q, cnt;
  logic [SEL_W-1:0] nxt;
  logic found, idle;
  assign idle = state == ST_IDLE;
  assign busy = !idle;
  assign done = state == ST_DONE;
  mux_scan_next u_next (
    .mask      (idle ? mask : mask_q),
    .cur       (s),
    .from_none (idle),
    .nxt       (nxt),
    .found     (found)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      s <= '0;
      result <= '0;
      cnt <= '0;
      mask_q <= '0;
      settle_q <= '0;
    end else
      case (state)
        ST_IDLE:
          if (start) begin
            mask_q <= mask;
            settle_q <= settle;
            result <= '0;
            cnt <= settle;
            if (found) s <= nxt;
            state <= found ? ST_SETTLE : ST_DONE;
          end
        ST_SETTLE:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            result[s] <= y_in;
            if (found) begin
              s <= nxt;
              cnt <= settle_q;
            end else state <= ST_DONE;
          end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl select sequencing, capture, latency and reset
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] mask = '0;
  logic [3:0] settle = '0;
  logic [3:0] d = '0;
  logic y_in;
  logic [1:0] s;
  logic [3:0] result;
  logic busy, done;
  typedef struct {
    logic [3:0] res;
    int lat;
  } exp_t;
  exp_t eq[$];
  logic [1:0] sq[$];
  int checks = 0;
  int fails = 0;
  assign y_in = d[s];
  always #5 clk = ~clk;
  mux_scan_ctrl #(.SETTLE_W(4), .NUM_CH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mask   (mask),
    .settle (settle),
    .y_in   (y_in),
    .s      (s),
    .result (result),
    .busy   (busy),
    .done   (done)
  );
  task automatic start_scan(input logic [3:0] m, input logic [3:0] st);
    exp_t e;
    e.res = m & d;
    e.lat = 0;
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int j = 0; j <= int'(st); j++) begin
          sq.push_back(2'(c));
          e.lat++;
        end
    eq.push_back(e);
    start = 1'b1;
    mask = m;
    settle = st;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int poke_at, input logic [3:0] poke_mask);
    int k;
    exp_t e;
    logic [1:0] x;
    k = 0;
    while (!done && k < 100) begin
      checks++;
      if (sq.size() == 0) begin
        fails++;
        $display("FAIL %s sel_seq: cycle %0d s=%0d but no select expected", name, k, s);
      end else begin
        x = sq.pop_front();
        if (s !== x) begin
          fails++;
          $display("FAIL %s sel_seq: cycle %0d s=%0d expected %0d", name, k, s, x);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL %s busy_scan: cycle %0d busy=%b expected 1", name, k, busy);
      end
      if (k == poke_at) begin
        start = 1'b1;
        mask = poke_mask;
        settle = 4'd0;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    e = eq.pop_front();
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: done=%b after %0d cycles expected 1", name, done, k);
    end
    checks++;
    if (k != e.lat) begin
      fails++;
      $display("FAIL %s latency: %0d cycles expected %0d", name, k, e.lat);
    end
    checks++;
    if (result !== e.res) begin
      fails++;
      $display("FAIL %s result: %b expected %b", name, result, e.res);
    end
    checks++;
    if (busy !== 1'b1 || sq.size() != 0) begin
      fails++;
      $display("FAIL %s done_state: busy=%b leftover=%0d expected busy=1 leftover=0", name, busy, sq.size());
    end
    sq.delete();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done_pulse: done=%b busy=%b expected 0 0", name, done, busy);
    end
    d = ~d;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== e.res) begin
      fails++;
      $display("FAIL %s hold: busy=%b result=%b expected 0 %b", name, busy, result, e.res);
    end
    d = ~d;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (s !== 2'b00 || result !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: s=%b result=%b busy=%b done=%b expected 00 0000 0 0", s, result, busy, done);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_full_scan();
    d = 4'b1010;
    start_scan(4'b1111, 4'd0);
    wait_done("full_scan", -1, 4'b0000);
  endtask
  task automatic test_empty_mask();
    logic [1:0] s0;
    s0 = s;
    d = 4'b1111;
    start_scan(4'b0000, 4'd5);
    checks++;
    if (s !== s0) begin
      fails++;
      $display("FAIL empty_sel: s=%0d expected %0d", s, s0);
    end
    wait_done("empty_mask", -1, 4'b0000);
  endtask
  task automatic test_sparse();
    d = 4'b1111;
    start_scan(4'b0101, 4'd2);
    wait_done("sparse", -1, 4'b0000);
  endtask
  task automatic test_back_to_back();
    d = 4'b1111;
    start_scan(4'b0101, 4'd1);
    wait_done("restart_ignored", 2, 4'b1111);
  endtask
  task automatic test_max_settle();
    d = 4'b1000;
    start_scan(4'b1000, 4'd15);
    wait_done("max_settle", -1, 4'b0000);
  endtask
  task automatic test_reset_mid_scan();
    int k;
    int pulses;
    d = 4'b1111;
    start_scan(4'b0111, 4'd3);
    k = 0;
    while (s !== 2'd2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (s !== 2'd2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reach_ch2: s=%0d busy=%b expected 2 1", s, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 2'b00 || result !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: s=%b result=%b busy=%b done=%b expected 00 0000 0 0", s, result, busy, done);
    end
    eq.delete();
    sq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL abort_no_done: %0d active cycles expected 0", pulses);
    end
    d = 4'b1001;
    start_scan(4'b1101, 4'd1);
    wait_done("after_reset", -1, 4'b0000);
  endtask
  initial begin
    test_reset();
    test_full_scan();
    test_empty_mask();
    test_sparse();
    test_back_to_back();
    test_max_settle();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_W, default 4: width of the settle-count input and internal counter.
REQ-002 SHALL have parameter NUM_CH, default 4: number of mux channels scanned; fixed at 4 for this release.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port start  input  1  scan request; sampled only in IDLE.
REQ-006 SHALL have port mask  input  4  channel enables; bit i=1 means channel i is scanned.
REQ-007 SHALL have port settle  input  SETTLE_W  number of wait cycles after each select change before sampling.
REQ-008 SHALL have port y_in  input  1  data bit returned by the downstream 4:1 mux.
REQ-009 SHALL have port s  output  2  select driven to the downstream mux.
REQ-010 SHALL have port result  output  4  captured bit per channel.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at scan completion.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, DONE.
REQ-014 IDLE: on start=1, SHALL latch mask and settle into mask_q/settle_q, clear result to 0, and load the counter with settle.
REQ-015 IDLE with start=1: if mask≠0, SHALL set s to the lowest enabled channel and go to SETTLE; if mask=0, SHALL go directly to DONE.
REQ-016 SETTLE with counter≠0: SHALL decrement the counter, keep s stable, and leave result unchanged.
REQ-017 SETTLE with counter=0: SHALL write y_in into result[s].
REQ-018 After the capture in REQ-017: if a higher enabled channel exists in mask_q, SHALL set s to the lowest such channel, reload the counter from settle_q, and stay in SETTLE; otherwise SHALL go to DONE.
REQ-019 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-020 Latency: with start accepted at edge 0 and N enabled channels, the last capture SHALL occur at edge N*(settle+1), and done SHALL be high in the cycle that follows.
REQ-021 settle=0 SHALL sample one cycle after each select change, giving one cycle per channel.
REQ-022 Disabled channels SHALL never be selected, and their result bits SHALL read 0.
REQ-023 start while busy=1 SHALL be ignored; mask and settle changes during a scan SHALL have no effect.
REQ-024 result SHALL hold its value from scan completion until the next accepted start.
REQ-025 s SHALL hold its last value in IDLE and DONE.
REQ-026 Counter arithmetic SHALL be unsigned SETTLE_W bits; the counter SHALL never underflow, because the decrement occurs only when the counter is non-zero.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, s=2'b00, result=4'b0000, busy=0, done=0, counter=0, mask_q=0, settle_q=0.
REQ-028 Reset asserted mid-scan SHALL abort the scan; no done pulse SHALL be produced for the aborted scan.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-030 Package mux_scan_pkg SHALL hold the state enumeration, NUM_CH=4, and SEL_W=2.
REQ-031 Sub-module mux_scan_next SHALL be a combinational priority finder: inputs mask_q and current channel; outputs next enabled channel and a found flag. The same block SHALL be used for the first-channel search, with a "none" start index.
REQ-032 All outputs SHALL be driven from registers; there SHALL be no combinational path from start or y_in to any output.

Verification
REQ-033 mask=4'b1111, settle=0, y_in driven as the mux of d=4'b1010 by s -> s steps 0,1,2,3 on consecutive cycles; result=4'b1010; done at cycle 5.
REQ-034 mask=4'b0101, settle=2, y_in=1 -> only s=0 and s=2 selected, 3 cycles each; result=4'b0101; done high after edge 6.
REQ-035 mask=4'b0000, start=1 -> busy for exactly 1 cycle, done pulses, result=0, s stays 0.
REQ-036 start pulsed again during a scan, and mask changed mid-scan -> second start ignored; scan completes with the original mask; exactly one done pulse.
REQ-037 rst_n pulled low asynchronously during SETTLE of channel 2 -> outputs are reset values before the next clock edge; no done pulse; a new start then scans normally.
REQ-038 settle=15 (maximum), mask=4'b1000 -> s=3 held for 16 cycles; capture at edge 16; done after edge 16.
